wb_compare_monitor: RTL

- Synthesizable lockstep checker that compares the writeback streams of two execution units issuing the same instruction sequence: stream A is the reference unit (e.g. pipeline MUL), stream B is the candidate (e.g. MULE).
- Buffers out-of-step results, pairs them in order and compares tag and value.
- Measures per-stream issue-to-writeback latency, counts matches and mismatches, and flags overflow, orphan writebacks and timeouts.
- Sits beside riscv_core on the issue/writeback taps; it is observational only and has no effect on the core.

---
 rtl/wb_compare_monitor_pkg.sv | 21 ++
 rtl/wbc_fifo.sv | 48 ++++
 rtl/wb_compare_monitor.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_compare_monitor_pkg.sv
// Shared definitions for the writeback lockstep monitor: sticky-flag bit
// positions, compare outcome encoding and the result-entry width helper.
package wb_compare_monitor_pkg;

    localparam int STK_OVERFLOW = 0;
    localparam int STK_ORPHAN   = 1;
    localparam int STK_TIMEOUT  = 2;
    localparam int STK_ERR      = 3;
    localparam int STK_W        = 4;

    typedef enum logic [1:0] {
        CMP_IDLE     = 2'd0,
        CMP_MATCH    = 2'd1,
        CMP_MISMATCH = 2'd2
    } cmp_e;

    function automatic int entry_w(input int tag_w, input int data_w);
        return tag_w + data_w;
    endfunction

endpackage

// File: rtl/wbc_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable. Push while full is accepted only if a pop frees a slot.
module wbc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_valid   = !w_empty;
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/wb_compare_monitor.sv
// Lockstep checker pairing reference (A) and candidate (B) writebacks in order,
// with per-stream issue-to-writeback latency and sticky anomaly flags.
module wb_compare_monitor
    import wb_compare_monitor_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              a_issue_i,
    input  logic              b_issue_i,
    input  logic              a_wb_valid_i,
    input  logic [TAG_W-1:0]  a_wb_tag_i,
    input  logic [DATA_W-1:0] a_wb_data_i,
    input  logic              b_wb_valid_i,
    input  logic [TAG_W-1:0]  b_wb_tag_i,
    input  logic [DATA_W-1:0] b_wb_data_i,
    output logic [CNT_W-1:0]  match_cnt_o,
    output logic [CNT_W-1:0]  mismatch_cnt_o,
    output logic              err_o,
    output logic [TAG_W-1:0]  err_tag_o,
    output logic [DATA_W-1:0] err_a_o,
    output logic [DATA_W-1:0] err_b_o,
    output logic [CNT_W-1:0]  lat_last_a_o,
    output logic [CNT_W-1:0]  lat_last_b_o,
    output logic [CNT_W-1:0]  lat_max_a_o,
    output logic [CNT_W-1:0]  lat_max_b_o,
    output logic              overflow_o,
    output logic              orphan_o,
    output logic              timeout_o
);

    localparam int EW     = entry_w(TAG_W, DATA_W);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_match;
    logic [CNT_W-1:0]  r_mismatch;
    logic [TAG_W-1:0]  r_err_tag;
    logic [DATA_W-1:0] r_err_a;
    logic [DATA_W-1:0] r_err_b;
    logic [CNT_W-1:0]  r_lat_last_a;
    logic [CNT_W-1:0]  r_lat_last_b;
    logic [CNT_W-1:0]  r_lat_max_a;
    logic [CNT_W-1:0]  r_lat_max_b;
    logic [STK_W-1:0]  r_sticky;
    logic [WAIT_W-1:0] r_wait;

    logic              w_ts_a_valid, w_ts_a_full, w_ts_b_valid, w_ts_b_full;
    logic [CNT_W-1:0]  w_ts_a_head, w_ts_b_head;
    logic              w_ra_valid, w_ra_full, w_rb_valid, w_rb_full;
    logic [EW-1:0]     w_ra_head, w_rb_head;
    logic              w_a_pop_ts, w_b_pop_ts;
    logic [CNT_W-1:0]  w_lat_a, w_lat_b;
    logic              w_pair;
    logic              w_ovf;
    logic              w_orphan;
    cmp_e              w_cmp;

    wbc_fifo #(.WIDTH(CNT_W), .DEPTH(DEPTH)) u_ts_a (
        .clk(clk), .rst(rst), .i_push(a_issue_i), .i_pop(w_a_pop_ts),
        .i_data(r_cycle), .o_valid(w_ts_a_valid), .o_full(w_ts_a_full),
        .o_head(w_ts_a_head)
    );

    wbc_fifo #(.WIDTH(CNT_W), .DEPTH(DEPTH)) u_ts_b (
        .clk(clk), .rst(rst), .i_push(b_issue_i), .i_pop(w_b_pop_ts),
        .i_data(r_cycle), .o_valid(w_ts_b_valid), .o_full(w_ts_b_full),
        .o_head(w_ts_b_head)
    );

    wbc_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_res_a (
        .clk(clk), .rst(rst), .i_push(a_wb_valid_i), .i_pop(w_pair),
        .i_data({a_wb_tag_i, a_wb_data_i}), .o_valid(w_ra_valid),
        .o_full(w_ra_full), .o_head(w_ra_head)
    );

    wbc_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_res_b (
        .clk(clk), .rst(rst), .i_push(b_wb_valid_i), .i_pop(w_pair),
        .i_data({b_wb_tag_i, b_wb_data_i}), .o_valid(w_rb_valid),
        .o_full(w_rb_full), .o_head(w_rb_head)
    );

    assign w_a_pop_ts = a_wb_valid_i && w_ts_a_valid;
    assign w_b_pop_ts = b_wb_valid_i && w_ts_b_valid;
    assign w_lat_a    = r_cycle - w_ts_a_head;
    assign w_lat_b    = r_cycle - w_ts_b_head;
    assign w_pair     = w_ra_valid && w_rb_valid;
    assign w_orphan   = (a_wb_valid_i && !w_ts_a_valid) ||
                        (b_wb_valid_i && !w_ts_b_valid);
    // A push into a full FIFO only loses data when no pop frees a slot that cycle.
    assign w_ovf      = (a_issue_i && w_ts_a_full && !w_a_pop_ts) ||
                        (b_issue_i && w_ts_b_full && !w_b_pop_ts) ||
                        (a_wb_valid_i && w_ra_full && !w_pair) ||
                        (b_wb_valid_i && w_rb_full && !w_pair);

    always_comb begin
        w_cmp = CMP_IDLE;
        if (w_pair) w_cmp = (w_ra_head == w_rb_head) ? CMP_MATCH : CMP_MISMATCH;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_cycle <= '0;
        else      r_cycle <= r_cycle + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            r_match    <= '0;
            r_mismatch <= '0;
            r_err_tag  <= '0;
            r_err_a    <= '0;
            r_err_b    <= '0;
            r_sticky   <= '0;
            r_wait     <= '0;
        end else begin
            if (w_cmp == CMP_MATCH) r_match <= sat_inc(r_match);
            if (w_cmp == CMP_MISMATCH) begin
                r_mismatch <= sat_inc(r_mismatch);
                if (!r_sticky[STK_ERR]) begin
                    r_sticky[STK_ERR] <= 1'b1;
                    r_err_tag         <= w_ra_head[EW-1 -: TAG_W];
                    r_err_a           <= w_ra_head[DATA_W-1:0];
                    r_err_b           <= w_rb_head[DATA_W-1:0];
                end
            end
            if (w_ovf)    r_sticky[STK_OVERFLOW] <= 1'b1;
            if (w_orphan) r_sticky[STK_ORPHAN]   <= 1'b1;
            if (w_pair || (!w_ra_valid && !w_rb_valid)) begin
                r_wait <= '0;
            end else if (r_wait != WAIT_W'(TIMEOUT)) begin
                r_wait <= r_wait + WAIT_W'(1);
                if (r_wait == WAIT_W'(TIMEOUT - 1)) r_sticky[STK_TIMEOUT] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            r_lat_last_a <= '0;
            r_lat_last_b <= '0;
            r_lat_max_a  <= '0;
            r_lat_max_b  <= '0;
        end else begin
            if (w_a_pop_ts) begin
                r_lat_last_a <= w_lat_a;
                if (w_lat_a > r_lat_max_a) r_lat_max_a <= w_lat_a;
            end
            if (w_b_pop_ts) begin
                r_lat_last_b <= w_lat_b;
                if (w_lat_b > r_lat_max_b) r_lat_max_b <= w_lat_b;
            end
        end
    end

    assign match_cnt_o    = r_match;
    assign mismatch_cnt_o = r_mismatch;
    assign err_o          = r_sticky[STK_ERR];
    assign err_tag_o      = r_err_tag;
    assign err_a_o        = r_err_a;
    assign err_b_o        = r_err_b;
    assign lat_last_a_o   = r_lat_last_a;
    assign lat_last_b_o   = r_lat_last_b;
    assign lat_max_a_o    = r_lat_max_a;
    assign lat_max_b_o    = r_lat_max_b;
    assign overflow_o     = r_sticky[STK_OVERFLOW];
    assign orphan_o       = r_sticky[STK_ORPHAN];
    assign timeout_o      = r_sticky[STK_TIMEOUT];

endmodule
